// File: rtl/adc_spi_responder.sv
// Stand-in for the quad ADC configuration port: decodes 24-bit SPI frames (R/W, addr, data),
// holds a 2**ADDR_W x 16 register file and returns read data on miso. Serial pins are oversampled on clk.
module adc_spi_responder #(
   parameter int          ADDR_W = 7,
   parameter logic [15:0] ID_VAL = 16'hA5C3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              adc_sclk,
   input  logic              adc_sen,
   input  logic              adc_mosi,
   input  logic              adc_rst,
   output logic              adc_miso,
   output logic              miso_oe,
   output logic              reg_wr_stb,
   output logic [ADDR_W-1:0] reg_wr_addr,
   output logic [15:0]       reg_wr_data,
   output logic              frame_err,
   output logic [2:0]        dbg_state_o
);
   typedef enum logic [2:0] {IDLE = 3'd0, HDR = 3'd1, WDATA = 3'd2, RDATA = 3'd3, FLUSH = 3'd4} state_t;
   localparam logic [ADDR_W-1:0] ID_ADDR = '1;

   logic [3:0]        sync1_q, sync2_q;   // {adc_rst, adc_mosi, adc_sen, adc_sclk}
   logic [1:0]        prev_q;             // {sen, sclk} one cycle behind sync2_q
   state_t            state_q, state_d;
   logic [4:0]        bit_cnt_q, bit_cnt_d;
   logic [15:0]       shift_in_q, shift_in_d;
   logic [15:0]       shift_out_q, shift_out_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              miso_q, miso_d, oe_q, oe_d, stb_q, stb_d, err_q, err_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [15:0]       wr_data_q, wr_data_d;
   logic [15:0]       regs_q [2**ADDR_W];
   logic              commit, wr_en, soft_clr;
   logic              sclk_s, sen_s, mosi_s, arst_s;
   logic              sclk_rise, sclk_fall, sen_rise, sen_fall;
   logic [6:0]        hdr_addr;
   logic [ADDR_W-1:0] new_addr;
   logic [15:0]       rd_val;

   assign sclk_s    = sync2_q[0];
   assign sen_s     = sync2_q[1];
   assign mosi_s    = sync2_q[2];
   assign arst_s    = sync2_q[3];
   assign sclk_rise = sclk_s & ~prev_q[0];
   assign sclk_fall = ~sclk_s & prev_q[0];
   assign sen_rise  = sen_s & ~prev_q[1];
   assign sen_fall  = ~sen_s & prev_q[1];

   // On the 8th rising edge the header is 7 shifted bits plus the bit being sampled now.
   assign hdr_addr = {shift_in_q[5:0], mosi_s};
   assign new_addr = hdr_addr[6 -: ADDR_W];
   assign rd_val   = (new_addr == ID_ADDR) ? ID_VAL : regs_q[new_addr];
   assign wr_en    = commit && (addr_q != ID_ADDR);
   assign soft_clr = stb_q && (wr_addr_q == '0) && wr_data_q[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
      end else begin
         sync1_q <= {adc_rst, adc_mosi, adc_sen, adc_sclk};
         sync2_q <= sync1_q;
         prev_q  <= sync2_q[1:0];
      end
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_in_d  = shift_in_q;
      shift_out_d = shift_out_q;
      addr_d      = addr_q;
      miso_d      = miso_q;
      oe_d        = oe_q;
      stb_d       = 1'b0;
      err_d       = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      commit      = 1'b0;
      if (arst_s) begin
         state_d   = IDLE;
         bit_cnt_d = '0;
         miso_d    = 1'b0;
         oe_d      = 1'b0;
      end else if (sen_rise) begin
         // Frame end takes priority over any sclk edge seen in the same cycle.
         state_d = IDLE;
         miso_d  = 1'b0;
         oe_d    = 1'b0;
         case (state_q)
            HDR:   err_d = 1'b1;
            WDATA: begin
               if (bit_cnt_q == 5'd24) begin
                  commit    = 1'b1;
                  stb_d     = 1'b1;
                  wr_addr_d = addr_q;
                  wr_data_d = shift_in_q;
               end else begin
                  err_d = 1'b1;
               end
            end
            RDATA: err_d = (bit_cnt_q != 5'd24);
            default: ;
         endcase
      end else if (state_q == IDLE) begin
         if (sen_fall) begin
            state_d   = HDR;
            bit_cnt_d = '0;
         end
      end else if (!sen_s) begin
         if (sclk_rise) begin
            shift_in_d = {shift_in_q[14:0], mosi_s};
            bit_cnt_d  = (bit_cnt_q == 5'd31) ? bit_cnt_q : bit_cnt_q + 5'd1;
            case (state_q)
               HDR: begin
                  if (bit_cnt_q == 5'd7) begin
                     addr_d = new_addr;
                     if (shift_in_q[6]) begin
                        state_d     = RDATA;
                        shift_out_d = rd_val;
                        oe_d        = 1'b1;
                     end else begin
                        state_d = WDATA;
                     end
                  end
               end
               WDATA, RDATA: begin
                  if (bit_cnt_q == 5'd24) begin
                     state_d = FLUSH;
                     err_d   = 1'b1;
                     miso_d  = 1'b0;
                     oe_d    = 1'b0;
                  end
               end
               default: ;
            endcase
         end else if (sclk_fall && state_q == RDATA) begin
            miso_d      = shift_out_q[15];
            shift_out_d = {shift_out_q[14:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         shift_in_q  <= '0;
         shift_out_q <= '0;
         addr_q      <= '0;
         miso_q      <= 1'b0;
         oe_q        <= 1'b0;
         stb_q       <= 1'b0;
         err_q       <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_in_q  <= shift_in_d;
         shift_out_q <= shift_out_d;
         addr_q      <= addr_d;
         miso_q      <= miso_d;
         oe_q        <= oe_d;
         stb_q       <= stb_d;
         err_q       <= err_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

   // Soft reset fires the cycle after the strobe, so the write to reg0 itself is wiped too.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2**ADDR_W; i++) regs_q[i] <= '0;
      end else if (arst_s || soft_clr) begin
         for (int i = 0; i < 2**ADDR_W; i++) regs_q[i] <= '0;
      end else if (wr_en) begin
         regs_q[addr_q] <= shift_in_q;
      end
   end

   assign adc_miso    = miso_q;
   assign miso_oe     = oe_q;
   assign reg_wr_stb  = stb_q;
   assign reg_wr_addr = wr_addr_q;
   assign reg_wr_data = wr_data_q;
   assign frame_err   = err_q;
   assign dbg_state_o = state_q;
endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: table of SPI frames with expected strobe/error/read data,
// plus hand-written sequences for adc_rst mid-frame and rst during the read-data phase.
module tb_adc_spi_responder;
   localparam int H = 8;   // sclk half period in clk cycles

   logic        clk, rst, adc_sclk, adc_sen, adc_mosi, adc_rst;
   logic        adc_miso, miso_oe, reg_wr_stb, frame_err;
   logic [6:0]  reg_wr_addr;
   logic [15:0] reg_wr_data;
   logic [2:0]  dbg_state_o;

   typedef struct {
      logic        rw;
      logic [6:0]  addr;
      logic [15:0] data;
      int          nbits;
      logic        exp_stb;
      logic        exp_err;
      logic [15:0] exp_rd;
      string       name;
   } vec_t;

   int          n_checks = 0;
   int          n_errors = 0;
   int          stb_cnt = 0;
   int          err_cnt = 0;
   logic [22:0] exp_q[$];     // {addr, data} of writes expected to commit
   logic [15:0] rd_exp_q[$];  // data expected back from complete reads
   vec_t        vecs[21];

   adc_spi_responder dut (
      .clk(clk), .rst(rst), .adc_sclk(adc_sclk), .adc_sen(adc_sen), .adc_mosi(adc_mosi),
      .adc_rst(adc_rst), .adc_miso(adc_miso), .miso_oe(miso_oe), .reg_wr_stb(reg_wr_stb),
      .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .frame_err(frame_err),
      .dbg_state_o(dbg_state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
      end
   endfunction

   function automatic vec_t mk(input logic rw, input logic [6:0] a, input logic [15:0] d, input int nb,
                               input logic s, input logic e, input logic [15:0] r, input string nm);
      vec_t v;
      v.rw = rw; v.addr = a; v.data = d; v.nbits = nb;
      v.exp_stb = s; v.exp_err = e; v.exp_rd = r; v.name = nm;
      return v;
   endfunction

   // Scoreboard side: every strobe pops the oldest expected write.
   always @(negedge clk) begin
      if (reg_wr_stb) begin
         stb_cnt++;
         if (exp_q.size() > 0) check("wr_bus", 32'({reg_wr_addr, reg_wr_data}), 32'(exp_q.pop_front()));
      end
      if (frame_err) err_cnt++;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic sclk_bit(input logic b, output logic m, output logic o);
      adc_mosi = b;
      wait_clk(H);
      m = adc_miso;
      o = miso_oe;
      adc_sclk = 1'b1;
      wait_clk(H);
      adc_sclk = 1'b0;
   endtask

   task automatic send_frame(input logic [23:0] w, input int nbits, output logic [15:0] rd, output int oe_hi);
      logic [23:0] sh;
      logic        m, o;
      sh = w; rd = '0; oe_hi = 0;
      adc_sen = 1'b0;
      wait_clk(H);
      for (int i = 0; i < nbits; i++) begin
         sclk_bit(sh[23], m, o);
         sh = sh << 1;
         if (i >= 8 && i < 24) rd = {rd[14:0], m};
         if (o) oe_hi++;
      end
      wait_clk(H);
      adc_sen = 1'b1;
      wait_clk(2 * H);
   endtask

   task automatic run_vec(input vec_t v);
      int          s0, e0, oe_hi;
      logic [15:0] rd;
      logic        full_rd;
      full_rd = v.rw && (v.nbits == 24);
      s0 = stb_cnt; e0 = err_cnt;
      if (v.exp_stb) exp_q.push_back({v.addr, v.data});
      if (full_rd) rd_exp_q.push_back(v.exp_rd);
      send_frame({v.rw, v.addr, v.data}, v.nbits, rd, oe_hi);
      check({v.name, "_stb"}, 32'(stb_cnt - s0), 32'(v.exp_stb));
      check({v.name, "_err"}, 32'(err_cnt - e0), 32'(v.exp_err));
      if (full_rd) begin
         check({v.name, "_rdata"}, 32'(rd), 32'(rd_exp_q.pop_front()));
         check({v.name, "_oe_periods"}, 32'(oe_hi), 32'd16);
      end
      check({v.name, "_idle_miso"}, 32'({miso_oe, adc_miso}), 32'd0);
   endtask

   initial begin
      logic [23:0] sh;
      logic        m, o;
      int          s0, e0;

      vecs[0]  = mk(1'b0, 7'h05, 16'h1234, 24, 1'b1, 1'b0, 16'h0000, "wr05");
      vecs[1]  = mk(1'b1, 7'h05, 16'h0000, 24, 1'b0, 1'b0, 16'h1234, "rd05");
      vecs[2]  = mk(1'b1, 7'h7F, 16'h0000, 24, 1'b0, 1'b0, 16'hA5C3, "rd_id");
      vecs[3]  = mk(1'b0, 7'h7F, 16'hFFFF, 24, 1'b1, 1'b0, 16'h0000, "wr_id");
      vecs[4]  = mk(1'b1, 7'h7F, 16'h0000, 24, 1'b0, 1'b0, 16'hA5C3, "rd_id_again");
      vecs[5]  = mk(1'b0, 7'h10, 16'hABCD, 20, 1'b0, 1'b1, 16'h0000, "wr_short");
      vecs[6]  = mk(1'b1, 7'h10, 16'h0000, 24, 1'b0, 1'b0, 16'h0000, "rd10");
      vecs[7]  = mk(1'b0, 7'h11, 16'h5555, 26, 1'b0, 1'b1, 16'h0000, "wr_long");
      vecs[8]  = mk(1'b1, 7'h11, 16'h0000, 24, 1'b0, 1'b0, 16'h0000, "rd11");
      vecs[9]  = mk(1'b0, 7'h03, 16'hBEEF, 24, 1'b1, 1'b0, 16'h0000, "wr03");
      vecs[10] = mk(1'b1, 7'h03, 16'h0000, 24, 1'b0, 1'b0, 16'hBEEF, "rd03");
      vecs[11] = mk(1'b0, 7'h00, 16'h0001, 24, 1'b1, 1'b0, 16'h0000, "wr_softrst");
      vecs[12] = mk(1'b1, 7'h03, 16'h0000, 24, 1'b0, 1'b0, 16'h0000, "rd03_cleared");
      vecs[13] = mk(1'b1, 7'h00, 16'h0000, 24, 1'b0, 1'b0, 16'h0000, "rd00_selfclr");
      vecs[14] = mk(1'b1, 7'h05, 16'h0000, 24, 1'b0, 1'b0, 16'h0000, "rd05_cleared");
      vecs[15] = mk(1'b0, 7'h2A, 16'h8001, 24, 1'b1, 1'b0, 16'h0000, "wr2a");
      vecs[16] = mk(1'b1, 7'h2A, 16'h0000, 24, 1'b0, 1'b0, 16'h8001, "rd2a");
      vecs[17] = mk(1'b1, 7'h06, 16'h0000, 10, 1'b0, 1'b1, 16'h0000, "rd_short");
      vecs[18] = mk(1'b0, 7'h00, 16'h0002, 24, 1'b1, 1'b0, 16'h0000, "wr00");
      vecs[19] = mk(1'b1, 7'h00, 16'h0000, 24, 1'b0, 1'b0, 16'h0002, "rd00");
      vecs[20] = mk(1'b1, 7'h2A, 16'h0000, 24, 1'b0, 1'b0, 16'h8001, "rd2a_again");

      // Clock/reset
      rst = 1'b1; adc_sclk = 1'b0; adc_sen = 1'b1; adc_mosi = 1'b0; adc_rst = 1'b0;
      wait_clk(3);
      check("rst_outs", 32'({adc_miso, miso_oe, reg_wr_stb, frame_err}), 32'd0);
      check("rst_wr_bus", 32'({reg_wr_addr, reg_wr_data}), 32'd0);
      check("rst_state", 32'(dbg_state_o), 32'd0);
      rst = 1'b0;
      wait_clk(6);

      for (int i = 0; i < 21; i++) run_vec(vecs[i]);

      // adc_rst asserted in the middle of a write: no strobe, no error, registers cleared
      run_vec(mk(1'b0, 7'h20, 16'h7777, 24, 1'b1, 1'b0, 16'h0000, "wr20"));
      run_vec(mk(1'b1, 7'h20, 16'h0000, 24, 1'b0, 1'b0, 16'h7777, "rd20"));
      s0 = stb_cnt; e0 = err_cnt;
      adc_sen = 1'b0;
      wait_clk(H);
      sh = {1'b0, 7'h21, 16'h4242};
      for (int i = 0; i < 12; i++) begin
         sclk_bit(sh[23], m, o);
         sh = sh << 1;
      end
      wait_clk(H);
      check("hdr_to_wdata", 32'(dbg_state_o), 32'd2);
      adc_rst = 1'b1;
      wait_clk(4);
      adc_rst = 1'b0;
      wait_clk(6);
      check("adc_rst_idle", 32'(dbg_state_o), 32'd0);
      for (int i = 12; i < 24; i++) begin
         sclk_bit(sh[23], m, o);
         sh = sh << 1;
      end
      wait_clk(H);
      adc_sen = 1'b1;
      wait_clk(2 * H);
      check("adc_rst_no_stb", 32'(stb_cnt - s0), 32'd0);
      check("adc_rst_no_err", 32'(err_cnt - e0), 32'd0);
      run_vec(mk(1'b1, 7'h20, 16'h0000, 24, 1'b0, 1'b0, 16'h0000, "rd20_cleared"));

      // rst during the read-data phase: miso and oe drop at once, next frame decodes cleanly
      run_vec(mk(1'b0, 7'h2A, 16'hFFFF, 24, 1'b1, 1'b0, 16'h0000, "wr2a_ff"));
      s0 = stb_cnt; e0 = err_cnt;
      adc_sen = 1'b0;
      wait_clk(H);
      sh = {1'b1, 7'h2A, 16'h0000};
      for (int i = 0; i < 12; i++) begin
         sclk_bit(sh[23], m, o);
         sh = sh << 1;
      end
      wait_clk(H);
      check("rd_phase_active", 32'({miso_oe, adc_miso}), 32'h3);
      #2 rst = 1'b1;
      #1 check("rst_async_miso", 32'({miso_oe, adc_miso}), 32'd0);
      check("rst_async_state", 32'(dbg_state_o), 32'd0);
      wait_clk(2);
      rst = 1'b0;
      wait_clk(4);
      adc_sen = 1'b1;
      wait_clk(2 * H);
      check("rst_mid_no_stb", 32'(stb_cnt - s0), 32'd0);
      check("rst_mid_no_err", 32'(err_cnt - e0), 32'd0);
      run_vec(mk(1'b0, 7'h33, 16'h1357, 24, 1'b1, 1'b0, 16'h0000, "wr33"));
      run_vec(mk(1'b1, 7'h33, 16'h0000, 24, 1'b0, 1'b0, 16'h1357, "rd33"));
      run_vec(mk(1'b1, 7'h2A, 16'h0000, 24, 1'b0, 1'b0, 16'h0000, "rd2a_after_rst"));

      check("wr_queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
